// File: rtl/divisor_sequencial.sv
// Unsigned sequential restoring divider: one quotient bit per clock.
// Shares the St/Idle/Done start-and-complete handshake of the shift-add multiplier.
// Ports:
//   Clk        system clock, all state changes on posedge
//   rst        synchronous active-high reset, aborts any running operation
//   Dividendo  dividend, sampled on the accepting edge only
//   Divisor    divisor, sampled on the accepting edge only
//   St         start request, honoured only while Idle=1
//   Quociente  quotient, registered, updated on entry to DONE
//   Resto      remainder, registered, updated on entry to DONE
//   Idle       high while ready to accept St
//   Done       one-cycle completion pulse
//   DivZero    high with Done when the latched divisor was 0, cleared on next accept
module divisor_sequencial #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Dividendo,
   input  logic [WIDTH-1:0] Divisor,
   input  logic             St,
   output logic [WIDTH-1:0] Quociente,
   output logic [WIDTH-1:0] Resto,
   output logic             Idle,
   output logic             Done,
   output logic             DivZero
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_reg, q_nxt;
   logic [WIDTH-1:0] d_reg, d_nxt;
   // Stored partial remainder is always < D, so WIDTH bits hold it;
   // the extra bit needed for full-range operands lives in the trial value t_c.
   logic [WIDTH-1:0] r_reg, r_nxt;
   logic [WIDTH:0]   t_c, diff_c;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] quo_nxt, res_nxt;
   logic             dz_nxt, idle_nxt, done_nxt, accept_c;

   // Next-state, datapath and output decode
   always_comb begin
      state_nxt = state;
      q_nxt     = q_reg;
      r_nxt     = r_reg;
      d_nxt     = d_reg;
      cnt_nxt   = cnt;
      quo_nxt   = Quociente;
      res_nxt   = Resto;
      dz_nxt    = DivZero;

      accept_c = St && Idle && (state == IDLE);
      t_c      = {r_reg, q_reg[WIDTH-1]};
      diff_c   = t_c - {1'b0, d_reg};

      // Idle/Done are registered one cycle behind the state; Idle also drops
      // on the accepting edge so it is never seen high while running.
      idle_nxt = (state == IDLE) && !accept_c;
      done_nxt = (state == DONE);

      case (state)
         IDLE: begin
            if (accept_c) begin
               if (Divisor == '0) begin
                  quo_nxt   = '1;
                  res_nxt   = Dividendo;
                  dz_nxt    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  d_nxt     = Divisor;
                  q_nxt     = Dividendo;
                  r_nxt     = '0;
                  cnt_nxt   = CW'(WIDTH - 1);
                  dz_nxt    = 1'b0;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (t_c >= {1'b0, d_reg}) begin
               r_nxt = diff_c[WIDTH-1:0];
               q_nxt = {q_reg[WIDTH-2:0], 1'b1};
            end else begin
               r_nxt = t_c[WIDTH-1:0];
               q_nxt = {q_reg[WIDTH-2:0], 1'b0};
            end
            if (cnt == '0) begin
               quo_nxt   = q_nxt;
               res_nxt   = r_nxt;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (rst) begin
         state     <= IDLE;
         q_reg     <= '0;
         r_reg     <= '0;
         d_reg     <= '0;
         cnt       <= '0;
         Quociente <= '0;
         Resto     <= '0;
         DivZero   <= 1'b0;
         Idle      <= 1'b1;
         Done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         q_reg     <= q_nxt;
         r_reg     <= r_nxt;
         d_reg     <= d_nxt;
         cnt       <= cnt_nxt;
         Quociente <= quo_nxt;
         Resto     <= res_nxt;
         DivZero   <= dz_nxt;
         Idle      <= idle_nxt;
         Done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial (WIDTH=32): the driver pushes expected
// results when it issues an operation; a monitor pops and compares on every Done.
module tb_divisor_sequencial;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   logic        Clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] Dividendo = '0;
   logic [31:0] Divisor = '0;
   logic        St = 1'b0;
   logic [31:0] Quociente, Resto;
   logic        Idle, Done, DivZero;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];

   divisor_sequencial #(.WIDTH(32)) dut (
      .Clk(Clk), .rst(rst), .Dividendo(Dividendo), .Divisor(Divisor), .St(St),
      .Quociente(Quociente), .Resto(Resto), .Idle(Idle), .Done(Done), .DivZero(DivZero)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every Done must match the oldest outstanding expectation
   always @(negedge Clk) begin
      if (!rst && Done) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got Done=1 expected no completion (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quociente", 64'(Quociente), 64'(e.q));
            chk("resto", 64'(Resto), 64'(e.r));
            chk("divzero", 64'(DivZero), 64'(e.dz));
            chk("idle_with_done", 64'(Idle), 64'd0);
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (!Idle && t < 100) begin
         @(negedge Clk);
         t++;
      end
      if (!Idle) chk("idle_timeout", 64'(Idle), 64'd1);
   endtask

   task automatic wait_done(input int k, input int lat, input string name);
      int t = 0;
      while (!Done && t < 200) begin
         @(negedge Clk);
         t++;
      end
      if (!Done) chk("done_timeout", 64'(Done), 64'd1);
      else       chk(name, 64'(cyc - k), 64'(lat));
   endtask

   // Issue one operation; optionally disturb St/operands while it runs
   task automatic do_op(input logic [31:0] n, input logic [31:0] d, input logic [31:0] q,
                        input logic [31:0] r, input logic dz, input int lat, input bit disturb);
      int k;
      exp_t e;
      wait_idle();
      Dividendo = n;
      Divisor   = d;
      St        = 1'b1;
      e.q = q; e.r = r; e.dz = dz;
      sb.push_back(e);
      @(negedge Clk);
      k  = cyc;
      St = 1'b0;
      if (disturb) begin
         repeat (3) @(negedge Clk);
         Dividendo = 32'd999;
         Divisor   = 32'd4;
         St        = 1'b1;
         @(negedge Clk);
         St        = 1'b0;
      end
      wait_done(k, lat, "latency");
   endtask

   initial begin
      int k, d1;
      exp_t e;
      logic [31:0] rn, rd;

      // 1. reset and first operation
      repeat (3) @(negedge Clk);
      chk("rst_idle", 64'(Idle), 64'd1);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_quo", 64'(Quociente), 64'd0);
      chk("rst_res", 64'(Resto), 64'd0);
      chk("rst_dz", 64'(DivZero), 64'd0);
      rst = 1'b0;
      @(negedge Clk);
      chk("post_rst_idle", 64'(Idle), 64'd1);
      do_op(32'd3300, 32'd20, 32'd165, 32'd0, 1'b0, 33, 1'b0);
      @(negedge Clk);
      chk("done_one_cycle", 64'(Done), 64'd0);

      // 2. back-to-back, plus output hold while idle
      do_op(32'h12345678, 32'h2, 32'h091A2B3C, 32'd0, 1'b0, 33, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         chk("idle_hold_q", 64'(Quociente), 64'h091A2B3C);
         chk("idle_hold_r", 64'(Resto), 64'd0);
      end
      do_op(32'hFFFFFFFF, 32'hFF, 32'h01010101, 32'd0, 1'b0, 33, 1'b0);
      do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);

      // 3. boundary operands
      do_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33, 1'b0);
      do_op(32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 33, 1'b0);
      do_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33, 1'b0);
      do_op(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, 1'b0);

      // 4. divide by zero, then DivZero clears
      do_op(32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 1, 1'b0);
      do_op(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 33, 1'b0);

      // 5a. St and operand changes during RUN are ignored
      do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);

      // 5b. St held high restarts on the first Idle cycle with the operands then present
      wait_idle();
      Dividendo = 32'd50;
      Divisor   = 32'd6;
      St        = 1'b1;
      e.q = 32'd8; e.r = 32'd2; e.dz = 1'b0;
      sb.push_back(e);
      @(negedge Clk);
      k = cyc;
      wait_done(k, 33, "hold_latency1");
      d1        = cyc;
      Dividendo = 32'd81;
      Divisor   = 32'd9;
      e.q = 32'd9; e.r = 32'd0; e.dz = 1'b0;
      sb.push_back(e);
      @(negedge Clk);
      chk("hold_first_idle", 64'(Idle), 64'd1);
      @(negedge Clk);
      chk("hold_restart", 64'(Idle), 64'd0);
      St = 1'b0;
      wait_done(d1, 35, "hold_latency2");

      // 6. reset mid-operation aborts without Done
      wait_idle();
      Dividendo = 32'd3300;
      Divisor   = 32'd20;
      St        = 1'b1;
      @(negedge Clk);
      k  = cyc;
      St = 1'b0;
      while (cyc < k + 9) @(negedge Clk);
      rst = 1'b1;
      @(negedge Clk);
      chk("abort_idle", 64'(Idle), 64'd1);
      chk("abort_done", 64'(Done), 64'd0);
      chk("abort_quo", 64'(Quociente), 64'd0);
      chk("abort_res", 64'(Resto), 64'd0);
      rst = 1'b0;
      repeat (45) @(negedge Clk);
      do_op(32'd3300, 32'd20, 32'd165, 32'd0, 1'b0, 33, 1'b0);

      // randomized operands against unsigned division
      for (int i = 0; i < 200; i++) begin
         rn = $urandom;
         rd = $urandom >> $urandom_range(0, 31);
         if (rd == 0) rd = 32'd1;
         do_op(rn, rd, rn / rd, rn % rd, 1'b0, 33, 1'b0);
      end

      repeat (3) @(negedge Clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
